id_hazard_controller: RTL and testbench

Sequencing controller for the decode stage. Each cycle it decides whether ID issues its decoded instruction to EXE, sends a NOP bubble, or freezes fetch.
- Covers load-use and no-forwarding RAW interlocks, the syscall drain/notify sequence, and instruction-cache-miss holds.
- Owns the WANT_FREEZE and SYS handshakes to fetch and the simulator.
- Keeps a saturating data-hazard stall counter for performance reporting.

---
 rtl/id_hazard_controller_if.sv | 45 ++++
 rtl/id_hazard_controller.sv | 116 +++++++++++
 tb/tb_id_hazard_controller.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_hazard_controller_if.sv
// Decode-stage hazard controller bus: ID/EXE/MEM pipeline inputs and the
// ID-to-EXE action outputs.
//   master : pipeline side (drives instruction/hazard info, receives actions)
//   slave  : controller side
// Signals: hit, Instr_Valid_IN, RegA_IN/UsesA_IN, RegB_IN/UsesB_IN,
//   Syscall_IN, SysNotify_IN, EXE_* and MEM_* writer info (in to slave);
//   Issue_OUT, Bubble_OUT, WANT_FREEZE, SYS, State_OUT, Stall_Count_OUT
//   (out of slave).
interface id_hazard_controller_if #(
  parameter int unsigned STALL_CNT_W = 16
);
  logic                   hit;
  logic                   Instr_Valid_IN;
  logic [4:0]             RegA_IN;
  logic                   UsesA_IN;
  logic [4:0]             RegB_IN;
  logic                   UsesB_IN;
  logic                   Syscall_IN;
  logic                   SysNotify_IN;
  logic [4:0]             EXE_WriteReg_IN;
  logic                   EXE_RegWrite_IN;
  logic                   EXE_MemRead_IN;
  logic [4:0]             MEM_WriteReg_IN;
  logic                   MEM_RegWrite_IN;
  logic                   Issue_OUT;
  logic                   Bubble_OUT;
  logic                   WANT_FREEZE;
  logic                   SYS;
  logic [1:0]             State_OUT;
  logic [STALL_CNT_W-1:0] Stall_Count_OUT;

  modport master (
    output hit, Instr_Valid_IN, RegA_IN, UsesA_IN, RegB_IN, UsesB_IN,
           Syscall_IN, SysNotify_IN, EXE_WriteReg_IN, EXE_RegWrite_IN,
           EXE_MemRead_IN, MEM_WriteReg_IN, MEM_RegWrite_IN,
    input  Issue_OUT, Bubble_OUT, WANT_FREEZE, SYS, State_OUT, Stall_Count_OUT
  );

  modport slave (
    input  hit, Instr_Valid_IN, RegA_IN, UsesA_IN, RegB_IN, UsesB_IN,
           Syscall_IN, SysNotify_IN, EXE_WriteReg_IN, EXE_RegWrite_IN,
           EXE_MemRead_IN, MEM_WriteReg_IN, MEM_RegWrite_IN,
    output Issue_OUT, Bubble_OUT, WANT_FREEZE, SYS, State_OUT, Stall_Count_OUT
  );
endinterface

// File: rtl/id_hazard_controller.sv
// Decode-stage sequencing controller: per cycle decides issue / NOP bubble /
// fetch freeze, handles RAW interlocks, syscall drain-then-notify, and
// icache-miss holds; counts data-hazard bubbles (saturating).
// Ports: CLK, RESET (sync, active-high), bus (id_hazard_controller_if.slave).
module id_hazard_controller #(
  parameter int unsigned SYS_DRAIN_CYCLES = 3,
  parameter bit          HAS_FORWARDING   = 1'b1,
  parameter int unsigned STALL_CNT_W      = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  id_hazard_controller_if.slave  bus
);

  localparam int unsigned DRAIN_W    = 3;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(SYS_DRAIN_CYCLES - 1);

  localparam logic [1:0] RUN   = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] FIRE  = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [DRAIN_W-1:0]     drain_q, drain_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic issue_c, bubble_c, freeze_c, sys_c;
  logic m_a_c, m_b_c, raw_e_c, raw_m_c, hazard_c;

  // RAW detection; register 0 is never a real dependency
  always_comb begin
    m_a_c   = bus.UsesA_IN & (bus.RegA_IN != 5'd0);
    m_b_c   = bus.UsesB_IN & (bus.RegB_IN != 5'd0);
    raw_e_c = bus.EXE_RegWrite_IN &
              ((m_a_c & (bus.RegA_IN == bus.EXE_WriteReg_IN)) |
               (m_b_c & (bus.RegB_IN == bus.EXE_WriteReg_IN)));
    raw_m_c = bus.MEM_RegWrite_IN &
              ((m_a_c & (bus.RegA_IN == bus.MEM_WriteReg_IN)) |
               (m_b_c & (bus.RegB_IN == bus.MEM_WriteReg_IN)));
    hazard_c = HAS_FORWARDING ? (raw_e_c & bus.EXE_MemRead_IN)
                              : (raw_e_c | raw_m_c);
  end

  // Next-state and action decode; a cache miss freezes everything in place
  always_comb begin
    state_d  = state_q;
    drain_d  = drain_q;
    stall_d  = stall_q;
    issue_c  = 1'b0;
    bubble_c = 1'b0;
    freeze_c = 1'b0;
    sys_c    = 1'b0;
    if (!bus.hit) begin
      freeze_c = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (!bus.Instr_Valid_IN) begin
            bubble_c = 1'b1;
          end else if (bus.Syscall_IN) begin
            bubble_c = 1'b1;
            freeze_c = 1'b1;
            state_d  = DRAIN;
            drain_d  = DRAIN_INIT;
          end else if (hazard_c) begin
            bubble_c = 1'b1;
            freeze_c = 1'b1;
            if (stall_q != '1) begin
              stall_d = stall_q + STALL_CNT_W'(1);
            end
          end else begin
            issue_c = 1'b1;
          end
        end
        DRAIN: begin
          bubble_c = 1'b1;
          freeze_c = 1'b1;
          if (drain_q != '0) begin
            drain_d = drain_q - DRAIN_W'(1);
          end else begin
            state_d = FIRE;
          end
        end
        FIRE: begin
          // fetch advances past the syscall this cycle
          sys_c    = bus.SysNotify_IN;
          bubble_c = 1'b1;
          state_d  = RUN;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= RUN;
      drain_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
    end
  end

  // Every output is held low while reset is asserted
  assign bus.Issue_OUT       = ~RESET & issue_c;
  assign bus.Bubble_OUT      = ~RESET & bubble_c;
  assign bus.WANT_FREEZE     = ~RESET & freeze_c;
  assign bus.SYS             = ~RESET & sys_c;
  assign bus.State_OUT       = RESET ? 2'd0 : state_q;
  assign bus.Stall_Count_OUT = RESET ? '0 : stall_q;

endmodule

// File: tb/tb_id_hazard_controller.sv
// Scoreboarded bench for id_hazard_controller: two instances (forwarding /
// drain 3 / 16-bit counter, and no-forwarding / drain 2 / 4-bit counter)
// share stimulus; a reference model predicts each cycle's actions.
module tb_id_hazard_controller;

  typedef struct packed {
    logic       rst, hit, valid;
    logic [4:0] ra; logic ua;
    logic [4:0] rb; logic ub;
    logic       sc, sn;
    logic [4:0] ew; logic erw, emr;
    logic [4:0] mw; logic mrw;
  } stim_t;

  typedef struct packed {
    logic        issue, bubble, freeze, sys;
    logic [1:0]  state;
    logic [15:0] stall;
  } exp_t;

  typedef struct packed { exp_t d0; exp_t d1; } pair_t;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  id_hazard_controller_if #(.STALL_CNT_W(16)) bus0 ();
  id_hazard_controller_if #(.STALL_CNT_W(4))  bus1 ();

  id_hazard_controller #(.SYS_DRAIN_CYCLES(3), .HAS_FORWARDING(1'b1), .STALL_CNT_W(16))
    dut0 (.CLK(CLK), .RESET(RESET), .bus(bus0.slave));
  id_hazard_controller #(.SYS_DRAIN_CYCLES(2), .HAS_FORWARDING(1'b0), .STALL_CNT_W(4))
    dut1 (.CLK(CLK), .RESET(RESET), .bus(bus1.slave));

  // Reference model: mode 0 run, 1 draining, 2 firing; left = drain cycles remaining
  int p_drain [2] = '{3, 2};
  bit p_fwd   [2] = '{1'b1, 1'b0};
  int p_max   [2] = '{65535, 15};
  int m_mode  [2];
  int m_left  [2];
  int m_stall [2];

  pair_t sb [$];
  int vectors = 0;
  int miscompares = 0;

  function automatic bit hazard(input int k, input stim_t s);
    logic [4:0] src [$];
    bit hit_e = 1'b0;
    bit hit_m = 1'b0;
    if (s.ua && s.ra != 5'd0) src.push_back(s.ra);
    if (s.ub && s.rb != 5'd0) src.push_back(s.rb);
    foreach (src[i]) begin
      if (s.erw && src[i] == s.ew) hit_e = 1'b1;
      if (s.mrw && src[i] == s.mw) hit_m = 1'b1;
    end
    return p_fwd[k] ? (hit_e && s.emr) : (hit_e || hit_m);
  endfunction

  task automatic model(input int k, input stim_t s, output exp_t e);
    e = '0;
    if (s.rst) begin
      m_mode[k] = 0; m_left[k] = 0; m_stall[k] = 0;
      return;
    end
    e.state = 2'(m_mode[k]);
    e.stall = 16'(m_stall[k]);
    if (!s.hit) begin
      e.freeze = 1'b1;
      return;
    end
    case (m_mode[k])
      0: begin
        if (!s.valid) e.bubble = 1'b1;
        else if (s.sc) begin
          e.bubble = 1'b1; e.freeze = 1'b1;
          m_mode[k] = 1; m_left[k] = p_drain[k];
        end else if (hazard(k, s)) begin
          e.bubble = 1'b1; e.freeze = 1'b1;
          if (m_stall[k] < p_max[k]) m_stall[k]++;
        end else e.issue = 1'b1;
      end
      1: begin
        e.bubble = 1'b1; e.freeze = 1'b1;
        m_left[k]--;
        if (m_left[k] == 0) m_mode[k] = 2;
      end
      default: begin
        e.sys = s.sn; e.bubble = 1'b1;
        m_mode[k] = 0;
      end
    endcase
  endtask

  task automatic drive(input stim_t s);
    RESET = s.rst;
    bus0.hit = s.hit;             bus1.hit = s.hit;
    bus0.Instr_Valid_IN = s.valid; bus1.Instr_Valid_IN = s.valid;
    bus0.RegA_IN = s.ra;          bus1.RegA_IN = s.ra;
    bus0.UsesA_IN = s.ua;         bus1.UsesA_IN = s.ua;
    bus0.RegB_IN = s.rb;          bus1.RegB_IN = s.rb;
    bus0.UsesB_IN = s.ub;         bus1.UsesB_IN = s.ub;
    bus0.Syscall_IN = s.sc;       bus1.Syscall_IN = s.sc;
    bus0.SysNotify_IN = s.sn;     bus1.SysNotify_IN = s.sn;
    bus0.EXE_WriteReg_IN = s.ew;  bus1.EXE_WriteReg_IN = s.ew;
    bus0.EXE_RegWrite_IN = s.erw; bus1.EXE_RegWrite_IN = s.erw;
    bus0.EXE_MemRead_IN = s.emr;  bus1.EXE_MemRead_IN = s.emr;
    bus0.MEM_WriteReg_IN = s.mw;  bus1.MEM_WriteReg_IN = s.mw;
    bus0.MEM_RegWrite_IN = s.mrw; bus1.MEM_RegWrite_IN = s.mrw;
  endtask

  // Apply one cycle of stimulus and queue the predicted response
  task automatic step(input stim_t s);
    exp_t e0, e1;
    @(posedge CLK);
    #1;
    drive(s);
    model(0, s, e0);
    model(1, s, e1);
    sb.push_back({e0, e1});
  endtask

  function automatic stim_t idle();
    stim_t s = '0;
    s.hit = 1'b1;
    s.valid = 1'b1;
    return s;
  endfunction

  task automatic check(input int k, input exp_t a, input exp_t e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL dut%0d vec%0d t=%0t: actual iss=%b bub=%b frz=%b sys=%b st=%0d cnt=%0d, required iss=%b bub=%b frz=%b sys=%b st=%0d cnt=%0d",
               k, vectors, $time, a.issue, a.bubble, a.freeze, a.sys, a.state, a.stall,
               e.issue, e.bubble, e.freeze, e.sys, e.state, e.stall);
    end
  endtask

  // Monitor: compare the DUT's current outputs against the oldest prediction
  initial begin
    pair_t p;
    exp_t a0, a1;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        p = sb.pop_front();
        a0 = {bus0.Issue_OUT, bus0.Bubble_OUT, bus0.WANT_FREEZE, bus0.SYS,
              bus0.State_OUT, bus0.Stall_Count_OUT};
        a1 = {bus1.Issue_OUT, bus1.Bubble_OUT, bus1.WANT_FREEZE, bus1.SYS,
              bus1.State_OUT, 16'(bus1.Stall_Count_OUT)};
        check(0, a0, p.d0);
        check(1, a1, p.d1);
      end
    end
  end

  initial begin
    stim_t s;
    s = idle(); s.rst = 1'b1;
    drive(s);
    repeat (2) step(s);

    // load-use, then producer gone
    s = idle(); s.erw = 1; s.emr = 1; s.ew = 5'd8; s.ra = 5'd8; s.ua = 1;
    step(s);
    s.erw = 0; step(s);
    // load into r0 read as r0
    s = idle(); s.erw = 1; s.emr = 1; s.ew = 5'd0; s.ra = 5'd0; s.ua = 1;
    step(s);
    // non-load EXE writer (forwarded only on dut0)
    s = idle(); s.erw = 1; s.ew = 5'd8; s.ra = 5'd8; s.ua = 1;
    step(s);
    // MEM writer on rt
    s = idle(); s.mrw = 1; s.mw = 5'd9; s.rb = 5'd9; s.ub = 1;
    step(s);

    // syscall with and without notify, Syscall_IN held through the sequence
    for (int n = 0; n < 2; n++) begin
      s = idle(); s.sc = 1; s.sn = (n == 0);
      repeat (6) step(s);
      s = idle(); repeat (2) step(s);
    end

    // miss during drain
    s = idle(); s.sc = 1; s.sn = 1;
    step(s);
    s = idle(); s.sn = 1; step(s);
    s.hit = 0; repeat (5) step(s);
    s.hit = 1; repeat (6) step(s);

    // syscall plus hazard together, then a long hazard to saturate dut1
    s = idle(); s.sc = 1; s.sn = 1; s.erw = 1; s.emr = 1; s.ew = 5'd3; s.ra = 5'd3; s.ua = 1;
    step(s);
    s.sc = 0; repeat (25) step(s);

    // reset in the middle of a syscall sequence
    s = idle(); s.sc = 1; s.sn = 1; step(s);
    s = idle(); s.sn = 1; step(s);
    s.rst = 1; repeat (2) step(s);
    s.rst = 0; repeat (6) step(s);

    // random traffic with a small register pool to make hazards common
    for (int i = 0; i < 3000; i++) begin
      s.rst   = ($urandom_range(199) == 0);
      s.hit   = ($urandom_range(9) != 0);
      s.valid = ($urandom_range(7) != 0);
      s.ra    = 5'($urandom_range(3));
      s.ua    = 1'($urandom_range(1));
      s.rb    = 5'($urandom_range(3));
      s.ub    = 1'($urandom_range(1));
      s.sc    = ($urandom_range(19) == 0);
      s.sn    = 1'($urandom_range(1));
      s.ew    = 5'($urandom_range(3));
      s.erw   = 1'($urandom_range(1));
      s.emr   = 1'($urandom_range(1));
      s.mw    = 5'($urandom_range(3));
      s.mrw   = 1'($urandom_range(1));
      step(s);
    end

    s = idle(); step(s);
    repeat (3) @(posedge CLK);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain_scoreboard: actual %0d pending, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
